// File: rtl/serial_add_seq_pkg.sv
// Shared types and sizing for the serial add/subtract sequencer.
package serial_add_seq_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
  localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_add_seq_add_slice.sv
// Combinational SLICE-bit adder used once per cycle by the sequencer.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] din1_i,
  input  logic [SLICE-1:0] din2_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, din1_i} + {1'b0, din2_i} + {{SLICE{1'b0}}, cin_i};
endmodule

// File: rtl/serial_add_seq.sv
// Multi-cycle add/subtract: one SLICE-bit chunk per clock, LSB first, carry
// held in a register between chunks; flags published on the last chunk.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_sub_i,
  input  logic [WIDTH-1:0] din1_i,
  input  logic [WIDTH-1:0] din2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             c_q, c_d, ovf_q, ovf_d, zero_q, zero_d, valid_q, valid_d;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  add_slice #(.SLICE(SLICE)) u_slice (
    .din1_i (a_q[idx_q*SLICE +: SLICE]),
    .din2_i (b_q[idx_q*SLICE +: SLICE]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = din1_i;
          b_d     = op_sub_i ? ~din2_i : din2_i;
          carry_d = op_sub_i;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          res_d[idx_q*SLICE +: SLICE] = slice_sum;
          carry_d = slice_cout;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = ST_DONE;
            sum_d   = res_d;
            c_d     = slice_cout;
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_d  = (res_d == '0);
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = (state_q != ST_RUN);
  assign busy_o  = (state_q == ST_RUN);
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign c_o     = c_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed plus random checks of serial_add_seq against a whole-word arithmetic model.
module tb_serial_add_seq;
  import serial_add_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, op_sub = 1'b0, flush = 1'b0;
  logic [31:0] din1 = '0, din2 = '0;
  logic        ready, busy, valid, c, ovf, zero;
  logic [31:0] sum;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_sum;
  logic        exp_c, exp_ovf, exp_zero;

  serial_add_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_sub_i(op_sub),
    .din1_i(din1), .din2_i(din2), .flush_i(flush),
    .ready_o(ready), .busy_o(busy), .valid_o(valid),
    .sum_o(sum), .c_o(c), .ovf_o(ovf), .zero_o(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer arithmetic on full words.
  task automatic model(input logic sub, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    if (sub) begin
      exp_sum = a - b;
      exp_c   = (a >= b);
      exp_ovf = (a[31] != b[31]) && (exp_sum[31] != a[31]);
    end else begin
      wide    = {1'b0, a} + {1'b0, b};
      exp_sum = wide[31:0];
      exp_c   = wide[32];
      exp_ovf = (a[31] == b[31]) && (exp_sum[31] != a[31]);
    end
    exp_zero = (exp_sum == 32'd0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".sum"},  sum,          exp_sum);
    chk({tag, ".c"},    {31'd0, c},    {31'd0, exp_c});
    chk({tag, ".ovf"},  {31'd0, ovf},  {31'd0, exp_ovf});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  task automatic run_op(input string tag, input logic sub, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!ready && k < 20) begin tick(); k++; end
    model(sub, a, b);
    op_sub = sub; din1 = a; din2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (k < 20) begin
      tick(); k++;
      if (valid) break;
    end
    chk({tag, ".latency"}, k, NSLICE);
    check_result(tag);
    $display("op %s sub=%0d a=%h b=%h -> sum=%h c=%0d ovf=%0d zero=%0d lat=%0d",
             tag, sub, a, b, sum, c, ovf, zero, k);
    tick();
    chk({tag, ".valid_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] first_sum;

    // Reset state
    tick(); tick();
    chk("rst.ready", {31'd0, ready}, 32'd1);
    chk("rst.busy",  {31'd0, busy},  32'd0);
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.sum",   sum, 32'd0);
    rst = 1'b0;
    tick();

    // Directed boundary cases
    run_op("add_wrap",  1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("add_wrap.const", sum, 32'h0000_0000);
    run_op("add_ovf",   1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_ovf.const", sum, 32'h8000_0000);
    run_op("sub_neg",   1'b1, 32'd5, 32'd7);
    chk("sub_neg.const", sum, 32'hFFFF_FFFE);
    run_op("sub_ovf",   1'b1, 32'h8000_0000, 32'd1);
    chk("sub_ovf.const", sum, 32'h7FFF_FFFF);

    // Start held through RUN with changing operands, then back-to-back in DONE
    model(1'b0, 32'h1111_1111, 32'h2222_2222);
    op_sub = 1'b0; din1 = 32'h1111_1111; din2 = 32'h2222_2222; start = 1'b1;
    tick();
    k = 0;
    while (k < 20) begin
      din1 = $urandom; din2 = $urandom; op_sub = 1'($urandom);
      tick(); k++;
      if (valid) break;
    end
    chk("hold.latency", k, NSLICE);
    check_result("hold");
    first_sum = sum;
    $display("op hold sum=%h lat=%0d", sum, k);
    op_sub = 1'b0; din1 = 32'h10; din2 = 32'h20;
    tick();
    start = 1'b0;
    k = 1;
    while (!valid && k < 30) begin tick(); k++; end
    chk("b2b.spacing", k, NSLICE + 1);
    chk("b2b.sum", sum, 32'h30);
    $display("op b2b first=%h second=%h spacing=%0d", first_sum, sum, k);
    model(1'b0, 32'h10, 32'h20);
    tick();

    // Flush at idx=3: no result, prior outputs preserved
    op_sub = 1'b1; din1 = 32'hDEAD_BEEF; din2 = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.ready", {31'd0, ready}, 32'd1);
    chk("flush.busy",  {31'd0, busy},  32'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) k++;
      tick();
    end
    chk("flush.no_valid", k, 32'd0);
    check_result("flush.keep");
    $display("op flush sum=%h (kept)", sum);

    // Asynchronous reset at idx=5
    op_sub = 1'b0; din1 = 32'hAAAA_0000; din2 = 32'h0000_5555; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst.sum",   sum, 32'd0);
    chk("arst.flags", {29'd0, c, ovf, zero}, 32'd0);
    chk("arst.valid", {31'd0, valid}, 32'd0);
    chk("arst.busy",  {31'd0, busy}, 32'd0);
    chk("arst.ready", {31'd0, ready}, 32'd1);
    $display("op reset mid-run sum=%h busy=%0d ready=%0d", sum, busy, ready);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_rst", 1'b0, 32'h0000_0100, 32'h0000_0023);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
